// File: rtl/ldpc_pkg.sv
// Shared constants, FSM state type and shifted-address helper for the
// combined LLR RAM read-out path.
package ldpc_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 8;
  localparam int Z         = 32;
  localparam int NUM_BLK   = 8;
  localparam int NUM_LLR   = Z * NUM_BLK;
  localparam int OUT_W     = 8;
  localparam int NUM_WORDS = NUM_LLR / OUT_W;
  localparam int ZW        = $clog2(Z);
  localparam int PK_W      = $clog2(OUT_W);
  localparam int WI_W      = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Address of read index k: the block part of k is kept, the in-block
  // offset is rotated by shift. Z is a power of two, so the ZW-bit add
  // wraps modulo Z by itself.
  function automatic logic [ADDR_W-1:0] shifted_addr(
    input logic [ADDR_W-1:0] k,
    input logic [ZW-1:0]     shift
  );
    logic [ZW-1:0] j;
    j = k[ZW-1:0] + shift;
    return {k[ADDR_W-1:ZW], j};
  endfunction

endpackage

// File: rtl/sync_fifo_2.sv
// Two-entry synchronous FIFO; the head entry is always visible on dout.
module sync_fifo_2
  import ldpc_pkg::*;
#(
  parameter int W = OUT_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, the write slot equals the head slot, so a push is only
  // safe if that head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = rd_ptr ? mem1 : mem0;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/combine_ram_readout.sv
// Reads every LLR of the combined RAM through port A, undoing the per-block
// cyclic shift, and packs the sign bits LSB-first into OUT_W-bit words.
//
// Output stream: a word transfers on a cycle where dout_valid && dout_ready.
// Once dout_valid rises, dout/dout_last hold until that transfer happens.
module combine_ram_readout
  import ldpc_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cyclic_shif,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(NUM_LLR - 1);
  localparam logic [PK_W-1:0]   PK_LAST   = PK_W'(OUT_W - 1);
  localparam logic [PK_W:0]     PEND_LAST = (PK_W + 1)'(OUT_W - 1);
  localparam logic [WI_W-1:0]   W_LAST    = WI_W'(NUM_WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] k;
  logic [ZW-1:0]     shift;
  logic              inflight;
  logic [PK_W-1:0]   pk_cnt;
  logic [OUT_W-1:0]  sr;
  logic [WI_W-1:0]   word_idx;

  logic              hard_bit;
  logic [OUT_W-1:0]  word_c;
  logic              push;
  logic              pop;
  logic [1:0]        fifo_count;
  logic              fifo_full_unused;
  logic              fifo_empty;
  logic [OUT_W:0]    fifo_head;
  logic [2:0]        occ_next;
  logic [PK_W:0]     bits_pending;
  logic              completes;
  logic              stall;
  logic              start_ok;
  logic              unused_bits;

  assign hard_bit     = ram_q[DATA_W-1];
  assign unused_bits  = ^{ram_q[DATA_W-2:0], cyclic_shif[ADDR_W-1:ZW]};

  assign push         = inflight && (pk_cnt == PK_LAST);
  assign pop          = !fifo_empty && dout_ready;
  assign occ_next     = {1'b0, fifo_count} + {2'b00, push} - {2'b00, pop};
  assign bits_pending = {1'b0, pk_cnt} + {{PK_W{1'b0}}, inflight};
  // A read whose bit would finish a word needs a free FIFO slot when it lands.
  assign completes    = (bits_pending == PEND_LAST);
  assign stall        = completes && (occ_next == 3'd2);

  assign ram_rd_en    = (state == READ) && !stall;
  assign ram_addr     = shifted_addr(k, shift);
  assign busy         = (state == READ) || (state == DRAIN);
  assign done         = (state == DONE);
  assign start_ok     = (state == IDLE) && start;

  assign dout_valid   = !fifo_empty;
  assign dout         = fifo_head[OUT_W-1:0];
  assign dout_last    = fifo_head[OUT_W];

  // Word as it will look once the arriving bit is dropped into its slot.
  always_comb begin
    word_c         = sr;
    word_c[pk_cnt] = hard_bit;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = READ;
      READ:    if (ram_rd_en && (k == K_LAST)) state_nxt = DRAIN;
      DRAIN:   if (pop && dout_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Read index, in-flight tracking and bit packer.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      k        <= '0;
      shift    <= '0;
      inflight <= 1'b0;
      pk_cnt   <= '0;
      sr       <= '0;
      word_idx <= '0;
    end else begin
      inflight <= ram_rd_en;
      if (start_ok) begin
        shift    <= cyclic_shif[ZW-1:0];
        k        <= '0;
        pk_cnt   <= '0;
        sr       <= '0;
        word_idx <= '0;
      end else if (ram_rd_en) begin
        k <= k + 1'b1;
      end
      if (inflight) begin
        if (push) begin
          pk_cnt   <= '0;
          sr       <= '0;
          word_idx <= word_idx + 1'b1;
        end else begin
          pk_cnt <= pk_cnt + 1'b1;
          sr     <= word_c;
        end
      end
    end
  end

  sync_fifo_2 #(.W(OUT_W + 1)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .din   ({(word_idx == W_LAST), word_c}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_combine_ram_readout.sv
// Bench for combine_ram_readout: RAM model, ready driver, scoreboard monitor.
module tb_combine_ram_readout;
  import ldpc_pkg::*;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cyclic_shif = '0;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q = '0;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic              dout_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [OUT_W:0]    exp_q[$];
  logic [OUT_W-1:0]  got [0:NUM_WORDS-1];
  int                hs_cnt = 0;
  int                frame_base = 0;
  int                ready_mode = 0;
  int                total = 0;
  int                bad = 0;

  combine_ram_readout dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .cyclic_shif (cyclic_shif),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_q       (ram_q),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done)
  );

  // Clock and reset block.
  always #5 sys_clk = ~sys_clk;

  // Port-A RAM with one cycle of read latency.
  always @(posedge sys_clk) if (ram_rd_en) ram_q <= mem[ram_addr];

  // Downstream ready: 0 = always accept, 1 = random, 2 = hold off.
  always @(posedge sys_clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: compares every handshaken word against exp_q.
  logic           last_hs_prev = 1'b0;
  logic           held_v = 1'b0;
  logic [OUT_W:0] held = '0;
  logic [OUT_W:0] exp_w;
  int             idx;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      last_hs_prev = 1'b0;
      held_v       = 1'b0;
    end else begin
      if (done || last_hs_prev) begin
        check("done_after_last", done, last_hs_prev);
        if (done) check("busy_low_at_done", busy, 0);
      end
      if (held_v) begin
        check("hold_valid", dout_valid, 1);
        check("hold_stable", {dout_last, dout}, held);
      end
      held_v       = dout_valid && !dout_ready;
      held         = {dout_last, dout};
      last_hs_prev = 1'b0;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got 0x%0h with nothing expected", dout);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {dout_last, dout}, exp_w);
        end
        idx = hs_cnt - frame_base;
        if (idx >= 0 && idx < NUM_WORDS) got[idx] = dout;
        hs_cnt++;
        last_hs_prev = dout_last;
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] sh);
    start       = 1'b1;
    cyclic_shif = sh;
    tick();
    start = 1'b0;
  endtask

  task automatic load_ramp();
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = a[DATA_W-1:0];
  endtask

  // Expected stream for the current RAM image and a given shift.
  task automatic push_model(input int sh);
    logic [OUT_W-1:0] w;
    int kk;
    int a;
    for (int wi = 0; wi < NUM_WORDS; wi++) begin
      w = '0;
      for (int b = 0; b < OUT_W; b++) begin
        kk   = wi * OUT_W + b;
        a    = (kk / Z) * Z + ((kk % Z) + sh) % Z;
        w[b] = mem[a][DATA_W-1];
      end
      exp_q.push_back({(wi == NUM_WORDS - 1), w});
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
      if (done) break;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: no done after %0d cycles", cyc);
    end
    tick();
  endtask

  task automatic end_frame();
    check("word_count", hs_cnt - frame_base, NUM_WORDS);
    check("queue_empty", exp_q.size(), 0);
  endtask

  int cyc;
  int n;
  int rd_cnt;

  initial begin
    load_ramp();

    // Reset values.
    repeat (3) tick();
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    sys_rst = 1'b0;
    tick();

    // Shift 0, ready held high: alternating 0x00 / 0xFF words.
    for (int w = 0; w < NUM_WORDS; w++)
      exp_q.push_back({(w == NUM_WORDS - 1), ((w % 2) == 1) ? 8'hFF : 8'h00});
    frame_base = hs_cnt;
    do_start(8'd0);
    check("first_rd_en", ram_rd_en, 1);
    check("first_addr", ram_addr, 0);
    check("busy_on", busy, 1);
    n = 0;
    while (!dout_valid && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("first_valid_latency", n - 1, OUT_W + 1);
    wait_done(cyc);
    check("frame_cycles_le_260", (n + cyc + 1) <= 260, 1);
    end_frame();

    // Shift 5.
    push_model(5);
    frame_base = hs_cnt;
    do_start(8'd5);
    check("shift5_first_addr", ram_addr, 5);
    wait_done(cyc);
    end_frame();
    check("shift5_word0", got[0], 8'hF8);
    check("shift5_word3", got[3], 8'h07);

    // Shift 37 reduces to 5.
    push_model(5);
    frame_base = hs_cnt;
    do_start(8'd37);
    check("shift37_first_addr", ram_addr, 5);
    wait_done(cyc);
    end_frame();
    check("shift37_word0", got[0], 8'hF8);
    check("shift37_word3", got[3], 8'h07);

    // Downstream held off for 40 cycles: reads stop at 2 words + 7 bits.
    push_model(9);
    frame_base = hs_cnt;
    ready_mode = 2;
    do_start(8'd9);
    rd_cnt = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (ram_rd_en) rd_cnt++;
    end
    check("stall_read_count", rd_cnt, 2 * OUT_W + OUT_W - 1);
    check("stall_rd_en_low", ram_rd_en, 0);
    check("stall_valid", dout_valid, 1);
    check("stall_busy", busy, 1);
    ready_mode = 0;
    wait_done(cyc);
    end_frame();

    // Random RAM, random ready, second start mid-frame is ignored.
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'($urandom_range(0, 15));
    push_model(13);
    frame_base = hs_cnt;
    ready_mode = 1;
    do_start(8'd13);
    repeat (50) tick();
    check("busy_mid_frame", busy, 1);
    do_start(8'd3);
    wait_done(cyc);
    end_frame();
    ready_mode = 0;
    tick();

    // Reset at word 10, then a clean frame.
    load_ramp();
    push_model(0);
    frame_base = hs_cnt;
    do_start(8'd0);
    n = 0;
    while ((hs_cnt - frame_base) < 10 && n < 500) begin
      tick();
      n++;
    end
    check("reached_word10", (hs_cnt - frame_base) >= 10, 1);
    sys_rst = 1'b1;
    tick();
    check("midrst_valid", dout_valid, 0);
    check("midrst_rd_en", ram_rd_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    sys_rst = 1'b0;
    tick();
    push_model(0);
    frame_base = hs_cnt;
    do_start(8'd0);
    wait_done(cyc);
    end_frame();
    check("post_rst_word1", got[1], 8'hFF);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
